// File: rtl/hex_display_scan.sv
// Time-multiplexed N-digit hex 7-segment scanner: shadow register, per-digit enable/dp, leading-zero blanking, blank gap.
// Latency: one clock from cnt/idx/shadow/inputs to seg/dp/an; no backpressure, the scan free-runs.
module hex_display_scan #(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic                  load,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   digit_en,
  input  logic                  lz_blank,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   an
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*N_DIGITS-1:0]   shadow;

  logic [N_DIGITS-1:0]     hi_zero;
  logic [N_DIGITS-1:0]     visible;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_vis;
  logic                    in_gap;
  logic                    show;

  function automatic logic [6:0] decode(input logic [3:0] h);
    case (h)
      4'h0: decode = 7'b0000001;
      4'h1: decode = 7'b1001111;
      4'h2: decode = 7'b0010010;
      4'h3: decode = 7'b0000110;
      4'h4: decode = 7'b1001100;
      4'h5: decode = 7'b0100100;
      4'h6: decode = 7'b0100000;
      4'h7: decode = 7'b0001111;
      4'h8: decode = 7'b0000000;
      4'h9: decode = 7'b0000100;
      4'hA: decode = 7'b0001000;
      4'hB: decode = 7'b1100000;
      4'hC: decode = 7'b1110010;
      4'hD: decode = 7'b1000010;
      4'hE: decode = 7'b0110000;
      default: decode = 7'b0111000;
    endcase
  endfunction

  generate
    if (BLANK_CYCLES > 0) begin : g_gap
      assign in_gap = (cnt < CW'(BLANK_CYCLES));
    end else begin : g_nogap
      assign in_gap = 1'b0;
    end
  endgenerate

  // hi_zero[k]: every shadow nibble from k up to the leftmost digit is zero.
  always_comb begin
    logic acc;
    acc     = 1'b1;
    hi_zero = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      acc        = acc & (shadow[4*k +: 4] == 4'h0);
      hi_zero[k] = acc;
    end
  end

  always_comb begin
    logic [N_DIGITS-1:0] lz_mask;
    lz_mask    = lz_blank ? hi_zero : '0;
    lz_mask[0] = 1'b0;
    visible    = digit_en & ~lz_mask;
  end

  // Select the current digit's nibble/dp/visibility with constant indices only.
  always_comb begin
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    cur_vis = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx == IW'(k)) begin
        cur_nib = shadow[4*k +: 4];
        cur_dp  = dp_in[k];
        cur_vis = visible[k];
      end
    end
  end

  assign show = cur_vis & ~in_gap;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      idx    <= '0;
      shadow <= '0;
      seg    <= 7'b1111111;
      dp     <= 1'b1;
      an     <= '1;
    end else begin
      if (load)
        shadow <= value;

      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (show) begin
        an  <= ~(N_DIGITS'(1) << idx);
        seg <= decode(cur_nib);
        dp  <= ~cur_dp;
      end else begin
        an  <= '1;
        seg <= 7'b1111111;
        dp  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hex_display_scan.sv
// Bench for hex_display_scan: a 4-digit and a 1-digit instance against a time-indexed reference model.
module tb_hex_display_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic        load;
  logic [3:0]  dp_in, digit_en;
  logic        lz_blank;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  logic [3:0]  value1;
  logic        load1;
  logic [0:0]  dp_in1, digit_en1;
  logic        lz_blank1;
  logic [6:0]  seg1;
  logic        dpo1;
  logic [0:0]  an1;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: cycles since the last reset edge and the two shadows.
  int          t = 0;
  logic [15:0] sh0 = '0;
  logic [3:0]  sh1 = '0;

  logic [6:0] seg_tbl [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b1110010, 7'b1000010, 7'b0110000, 7'b0111000};

  localparam logic [15:0] DARK = {8'hFF, 7'b1111111, 1'b1};

  hex_display_scan #(.N_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .value(value), .load(load), .dp_in(dp_in),
    .digit_en(digit_en), .lz_blank(lz_blank), .seg(seg), .dp(dp), .an(an));

  hex_display_scan #(.N_DIGITS(1), .REFRESH_DIV(8), .BLANK_CYCLES(2)) dut1 (
    .clk(clk), .rst(rst), .value(value1), .load(load1), .dp_in(dp_in1),
    .digit_en(digit_en1), .lz_blank(lz_blank1), .seg(seg1), .dp(dpo1), .an(an1));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected {an(8, upper bits dark), seg, dp} for an n-digit display at scan time t.
  function automatic logic [15:0] exp_out(input int n, input logic [31:0] sh, input logic [7:0] dpv,
                                          input logic [7:0] env, input logic lz, input int tt);
    int   c, d;
    logic lzb;
    c   = tt % 8;
    d   = (tt / 8) % n;
    lzb = lz && (d != 0) && ((sh >> (4 * d)) == 32'd0);
    if (c < 2 || !env[d] || lzb)
      return DARK;
    return {8'hFF ^ (8'd1 << d), seg_tbl[sh[4*d +: 4]], ~dpv[d]};
  endfunction

  // One clock: predict from pre-edge state and inputs, advance model, compare both DUTs.
  task automatic cycle();
    logic [15:0] e0, e1;
    if (rst) begin
      e0 = DARK;
      e1 = DARK;
    end else begin
      e0 = exp_out(4, {16'h0, sh0}, {4'h0, dp_in}, {4'h0, digit_en}, lz_blank, t);
      e1 = exp_out(1, {28'h0, sh1}, {7'h0, dp_in1}, {7'h0, digit_en1}, lz_blank1, t);
    end
    @(posedge clk);
    if (rst) begin
      t   = 0;
      sh0 = '0;
      sh1 = '0;
    end else begin
      t++;
      if (load)  sh0 = value;
      if (load1) sh1 = value1;
    end
    @(negedge clk);
    check("scan4", {4'hF, an, seg, dp}, {16'h0, e0});
    check("scan1", {7'h7F, an1, seg1, dpo1}, {16'h0, e1});
  endtask

  // Reset, load v, then check the cnt=2 point of slots 0..3 and the wrap back to slot 0.
  task automatic run_slots(input string tag, input logic [15:0] v, input logic [11:0] l0,
                           input logic [11:0] l1, input logic [11:0] l2, input logic [11:0] l3);
    logic [11:0] lit [4];
    lit = '{l0, l1, l2, l3};
    rst = 1'b1; cycle();
    rst = 1'b0; value = v; load = 1'b1; cycle();
    load = 1'b0; cycle(); cycle();
    for (int j = 0; j < 5; j++) begin
      if (j > 0) repeat (8) cycle();
      check($sformatf("%s_slot%0d", tag, j), {20'h0, an, seg, dp}, {20'h0, lit[j % 4]});
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; value = '0; dp_in = '0; digit_en = 4'hF; lz_blank = 1'b0;
    load1 = 1'b0; value1 = '0; dp_in1 = '0; digit_en1 = 1'b1; lz_blank1 = 1'b0;

    repeat (3) cycle();
    check("reset_out", {20'h0, an, seg, dp}, 32'hFFF);

    rst = 1'b0;
    repeat (3) cycle();
    check("first_digit", {20'h0, an, seg, dp}, {20'h0, 4'b1110, 7'b0000001, 1'b1});

    run_slots("scan1234", 16'h1234, {4'b1110, 7'b1001100, 1'b1}, {4'b1101, 7'b0000110, 1'b1},
              {4'b1011, 7'b0010010, 1'b1}, {4'b0111, 7'b1001111, 1'b1});
    repeat (6) cycle();
    check("blank_gap", {28'h0, an}, 32'hF);

    lz_blank = 1'b1;
    run_slots("lz0050", 16'h0050, {4'b1110, 7'b0000001, 1'b1}, {4'b1101, 7'b0100100, 1'b1},
              12'hFFF, 12'hFFF);
    run_slots("lz0000", 16'h0000, {4'b1110, 7'b0000001, 1'b1}, 12'hFFF, 12'hFFF, 12'hFFF);
    lz_blank = 1'b0;

    digit_en = 4'b0101; dp_in = 4'b0100;
    run_slots("en_dp", 16'h8888, {4'b1110, 7'b0000000, 1'b1}, 12'hFFF,
              {4'b1011, 7'b0000000, 1'b0}, 12'hFFF);
    digit_en = 4'hF; dp_in = 4'h0;

    // Reset while digit 2 is lit with cnt=5.
    rst = 1'b1; cycle();
    rst = 1'b0; value = 16'hABCD; load = 1'b1; cycle();
    load = 1'b0;
    repeat (20) cycle();
    check("pre_midrst", {20'h0, an, seg, dp}, {20'h0, 4'b1011, 7'b1100000, 1'b1});
    rst = 1'b1; cycle();
    check("midrst_out", {20'h0, an, seg, dp}, 32'hFFF);
    rst = 1'b0;
    repeat (3) cycle();
    check("post_midrst", {20'h0, an, seg, dp}, {20'h0, 4'b1110, 7'b0000001, 1'b1});

    for (int v = 0; v < 16; v++) begin
      value1 = 4'(v); load1 = 1'b1; cycle();
      load1 = 1'b0; cycle();
      while (((t - 1) % 8) < 2) cycle();
      check($sformatf("decode_%h", v), {24'h0, an1, seg1}, {24'h0, 1'b0, seg_tbl[v]});
    end

    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 299) == 0);
      load = ($urandom_range(0, 7) == 0);
      for (int k = 0; k < 4; k++)
        value[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        digit_en = 4'($urandom) | 4'($urandom);
        dp_in    = 4'($urandom);
        lz_blank = 1'($urandom);
      end
      load1     = ($urandom_range(0, 7) == 0);
      value1    = 4'($urandom);
      digit_en1 = ($urandom_range(0, 9) != 0);
      dp_in1    = 1'($urandom);
      lz_blank1 = 1'($urandom);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
